// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the 128-to-32 Wishbone data-size bridge.
// Holds the bridge FSM encoding, lane geometry and the lane-mask helper.
package wb_bridge_pkg;

  localparam int unsigned NumLanes   = 4;
  localparam int unsigned LaneWidth  = 32;
  localparam int unsigned SelPerLane = LaneWidth / 8;
  localparam int unsigned LaneIdxW   = $clog2(NumLanes);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } bridge_state_e;

  // One bit per 32-bit lane: set when any byte select of that lane is active.
  function automatic logic [NumLanes-1:0] lane_mask(input logic [NumLanes*SelPerLane-1:0] sel);
    logic [NumLanes-1:0] m;
    m = '0;
    for (int unsigned n = 0; n < NumLanes; n++) begin
      m[n] = |sel[n*SelPerLane +: SelPerLane];
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_lane_pri_enc.sv
// Lowest-pending-lane priority encoder.
// Ports:
//   mask_i  - pending lane mask, bit n set when lane n still needs an access
//   idx_o   - index of the lowest set bit (0 when mask is empty)
//   valid_o - high when any bit of mask_i is set
module wb_lane_pri_enc
  import wb_bridge_pkg::*;
(
  input  logic [NumLanes-1:0] mask_i,
  output logic [LaneIdxW-1:0] idx_o,
  output logic                valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(NumLanes) - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = LaneIdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_dsize_128to32.sv
// 128-bit Wishbone slave to 32-bit Wishbone master data-size bridge.
// One upstream access is split into one downstream access per active 32-bit lane,
// lowest lane first, with no endian conversion. All outputs are registered.
// Ports:
//   i_clk, i_rst_n      - clock, asynchronous active-low reset
//   i_s_wb_*            - 128-bit upstream request (adr, sel, we, wdat, cyc, stb)
//   o_s_wb_*            - upstream response (rdat, ack, err)
//   o_m_wb_*            - 32-bit downstream request (adr, sel, we, wdat, cyc, stb)
//   i_m_wb_*            - downstream response (rdat, ack, err)
// TIMEOUT_CYCLES: downstream cycles without ack/err before the access errors out.
module wb_dsize_128to32
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [31:0]  i_s_wb_adr,
  input  logic [15:0]  i_s_wb_sel,
  input  logic         i_s_wb_we,
  input  logic [127:0] i_s_wb_wdat,
  input  logic         i_s_wb_cyc,
  input  logic         i_s_wb_stb,
  output logic [127:0] o_s_wb_rdat,
  output logic         o_s_wb_ack,
  output logic         o_s_wb_err,
  output logic [31:0]  o_m_wb_adr,
  output logic [3:0]   o_m_wb_sel,
  output logic         o_m_wb_we,
  output logic [31:0]  o_m_wb_wdat,
  output logic         o_m_wb_cyc,
  output logic         o_m_wb_stb,
  input  logic [31:0]  i_m_wb_rdat,
  input  logic         i_m_wb_ack,
  input  logic         i_m_wb_err
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  bridge_state_e state_q, state_d;
  logic [27:0]   adr_q, adr_d;  // 16-byte aligned upper address
  logic [15:0]   sel_q, sel_d;
  logic          we_q, we_d;
  logic [127:0]  wdat_q, wdat_d;
  logic [3:0]    mask_q, mask_d, mask_nxt;
  logic [1:0]    lane_q, lane_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [127:0]  rbuf_q, rbuf_d;

  logic [127:0]  s_rdat_q, s_rdat_d;
  logic          s_ack_q, s_ack_d, s_err_q, s_err_d;
  logic [31:0]   m_adr_q, m_adr_d, m_wdat_q, m_wdat_d;
  logic [3:0]    m_sel_q, m_sel_d;
  logic          m_we_q, m_we_d, m_cyc_q, m_cyc_d, m_stb_q, m_stb_d;

  logic [27:0]   cur_adr;
  logic [15:0]   cur_sel;
  logic          cur_we;
  logic [127:0]  cur_wdat;
  logic [1:0]    enc_idx;
  logic          enc_valid;
  logic          drive, to_resp;
  logic          unused_adr;

  // Byte offset within the 128-bit word is implied by sel.
  assign unused_adr = ^i_s_wb_adr[3:0];

  // Pending mask as it will be after this cycle; the encoder picks the next lane from it.
  always_comb begin
    mask_nxt = mask_q;
    if (state_q == StIdle) begin
      mask_nxt = lane_mask(i_s_wb_sel);
    end else if (state_q == StAccess && i_m_wb_ack && !i_m_wb_err) begin
      mask_nxt[lane_q] = 1'b0;
    end
  end

  wb_lane_pri_enc u_pri_enc (
    .mask_i  (mask_nxt),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    mask_d   = mask_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rbuf_d   = rbuf_q;
    s_rdat_d = s_rdat_q;
    s_ack_d  = 1'b0;
    s_err_d  = 1'b0;
    m_adr_d  = m_adr_q;
    m_sel_d  = m_sel_q;
    m_we_d   = m_we_q;
    m_wdat_d = m_wdat_q;
    m_cyc_d  = m_cyc_q;
    m_stb_d  = m_stb_q;
    drive    = 1'b0;
    to_resp  = 1'b0;
    cur_adr  = adr_q;
    cur_sel  = sel_q;
    cur_we   = we_q;
    cur_wdat = wdat_q;

    case (state_q)
      StIdle: begin
        if (i_s_wb_cyc && i_s_wb_stb) begin
          adr_d    = i_s_wb_adr[31:4];
          sel_d    = i_s_wb_sel;
          we_d     = i_s_wb_we;
          wdat_d   = i_s_wb_wdat;
          cur_adr  = i_s_wb_adr[31:4];
          cur_sel  = i_s_wb_sel;
          cur_we   = i_s_wb_we;
          cur_wdat = i_s_wb_wdat;
          mask_d   = mask_nxt;
          rbuf_d   = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (enc_valid) drive = 1'b1;
          else           to_resp = 1'b1;
        end
      end
      StAccess: begin
        if (i_m_wb_err) begin
          // Error takes priority over a simultaneous ack; remaining lanes are dropped.
          err_d   = 1'b1;
          mask_d  = '0;
          to_resp = 1'b1;
        end else if (i_m_wb_ack) begin
          if (!we_q) rbuf_d[{lane_q, 5'd0} +: 32] = i_m_wb_rdat;
          mask_d = mask_nxt;
          cnt_d  = '0;
          if (enc_valid) drive = 1'b1;
          else           to_resp = 1'b1;
        end else if (cnt_q + 16'd1 == TimeoutVal) begin
          err_d   = 1'b1;
          mask_d  = '0;
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (drive) begin
      state_d  = StAccess;
      lane_d   = enc_idx;
      m_adr_d  = {cur_adr, enc_idx, 2'b00};
      m_sel_d  = cur_sel[{enc_idx, 2'b00} +: 4];
      m_we_d   = cur_we;
      m_wdat_d = cur_wdat[{enc_idx, 5'd0} +: 32];
      m_cyc_d  = 1'b1;
      m_stb_d  = 1'b1;
    end

    // Response is suppressed if the upstream master has already abandoned the cycle.
    if (to_resp) begin
      state_d  = StResp;
      m_cyc_d  = 1'b0;
      m_stb_d  = 1'b0;
      s_rdat_d = rbuf_d;
      s_ack_d  = ~err_d & i_s_wb_cyc;
      s_err_d  = err_d & i_s_wb_cyc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      wdat_q   <= '0;
      mask_q   <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rbuf_q   <= '0;
      s_rdat_q <= '0;
      s_ack_q  <= 1'b0;
      s_err_q  <= 1'b0;
      m_adr_q  <= '0;
      m_sel_q  <= '0;
      m_we_q   <= 1'b0;
      m_wdat_q <= '0;
      m_cyc_q  <= 1'b0;
      m_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      wdat_q   <= wdat_d;
      mask_q   <= mask_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rbuf_q   <= rbuf_d;
      s_rdat_q <= s_rdat_d;
      s_ack_q  <= s_ack_d;
      s_err_q  <= s_err_d;
      m_adr_q  <= m_adr_d;
      m_sel_q  <= m_sel_d;
      m_we_q   <= m_we_d;
      m_wdat_q <= m_wdat_d;
      m_cyc_q  <= m_cyc_d;
      m_stb_q  <= m_stb_d;
    end
  end

  assign o_s_wb_rdat = s_rdat_q;
  assign o_s_wb_ack  = s_ack_q;
  assign o_s_wb_err  = s_err_q;
  assign o_m_wb_adr  = m_adr_q;
  assign o_m_wb_sel  = m_sel_q;
  assign o_m_wb_we   = m_we_q;
  assign o_m_wb_wdat = m_wdat_q;
  assign o_m_wb_cyc  = m_cyc_q;
  assign o_m_wb_stb  = m_stb_q;

endmodule

// File: tb/tb_wb_dsize_128to32.sv
module tb_wb_dsize_128to32;

  localparam int TO = 8;

  logic         clk, rst_n;
  logic [31:0]  s_adr;
  logic [15:0]  s_sel;
  logic         s_we;
  logic [127:0] s_wdat;
  logic         s_cyc, s_stb;
  logic [127:0] s_rdat;
  logic         s_ack, s_err;
  logic [31:0]  m_adr, m_wdat;
  logic [3:0]   m_sel;
  logic         m_we, m_cyc, m_stb;
  logic [31:0]  m_rdat;
  logic         m_ack, m_err;

  wb_dsize_128to32 #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_s_wb_adr  (s_adr),
    .i_s_wb_sel  (s_sel),
    .i_s_wb_we   (s_we),
    .i_s_wb_wdat (s_wdat),
    .i_s_wb_cyc  (s_cyc),
    .i_s_wb_stb  (s_stb),
    .o_s_wb_rdat (s_rdat),
    .o_s_wb_ack  (s_ack),
    .o_s_wb_err  (s_err),
    .o_m_wb_adr  (m_adr),
    .o_m_wb_sel  (m_sel),
    .o_m_wb_we   (m_we),
    .o_m_wb_wdat (m_wdat),
    .o_m_wb_cyc  (m_cyc),
    .o_m_wb_stb  (m_stb),
    .i_m_wb_rdat (m_rdat),
    .i_m_wb_ack  (m_ack),
    .i_m_wb_err  (m_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-wait downstream slave: per-lane read words, optional error lane, optional silence.
  logic [31:0] slv_word [4];
  int          slv_err_lane;
  bit          slv_silent, slv_both;

  always_comb begin
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_rdat = 32'h0;
    if (m_cyc && m_stb && !slv_silent) begin
      m_rdat = slv_word[m_adr[3:2]];
      if (int'(m_adr[3:2]) == slv_err_lane) begin
        m_err = 1'b1;
        m_ack = slv_both;
      end else begin
        m_ack = 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
  } ds_t;

  ds_t          exp_q[$];
  bit           exp_resp_valid, exp_resp_err;
  logic [127:0] exp_resp_rdat;
  int           n_checks, n_pass;
  int           ds_beats, stb_cycles;
  logic [31:0]  last_ds_adr;
  logic [3:0]   last_ds_sel;
  logic [127:0] last_rdat;
  logic         last_resp_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle comparison of DUT outputs against the expected transaction.
  task automatic sample();
    check("no_x", 128'($isunknown({s_rdat, s_ack, s_err, m_adr, m_sel, m_we, m_wdat,
                                    m_cyc, m_stb})), 128'(0));
    check("cyc_eq_stb", 128'(m_cyc), 128'(m_stb));
    if (m_cyc && m_stb) begin
      stb_cycles++;
      check("ds_expected", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) check("ds_beat", {m_adr, m_sel, m_we, m_wdat}, exp_q[0]);
      last_ds_adr = m_adr;
      last_ds_sel = m_sel;
      if (m_ack || m_err) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        ds_beats++;
      end
    end
    if (s_ack || s_err) begin
      check("us_expected", 128'(exp_resp_valid), 128'(1));
      check("us_kind", 128'({s_ack, s_err}), exp_resp_err ? 128'(2'b01) : 128'(2'b10));
      check("us_rdat", s_rdat, exp_resp_rdat);
      exp_resp_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  // Drive one upstream access from a negedge. The model lists the expected downstream
  // beats and response from the byte selects and slave behaviour.
  task automatic run_txn(input string name, input logic [31:0] adr, input logic [15:0] sel,
                         input logic we, input logic [127:0] wdat, input bit drop_cyc,
                         input int rst_lane);
    logic [127:0] rd;
    bit           is_err, rst_hit;
    int           issued, lat, got, pops;
    ds_t          e;
    rd = '0; is_err = 0; issued = 0; rst_hit = 0;
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      if (sel[4*n +: 4] != 4'h0 && !is_err) begin
        e.adr  = {adr[31:4], 2'(n), 2'b00};
        e.sel  = sel[4*n +: 4];
        e.we   = we;
        e.wdat = wdat[32*n +: 32];
        exp_q.push_back(e);
        issued++;
        if (slv_silent || n == slv_err_lane) is_err = 1;
        else if (!we) rd[32*n +: 32] = slv_word[n];
      end
    end
    lat  = (slv_silent && issued > 0) ? TO + 1 : issued + 1;
    pops = slv_silent ? 0 : issued;
    exp_resp_valid = !drop_cyc && rst_lane < 0;
    exp_resp_err   = is_err;
    exp_resp_rdat  = rd;
    ds_beats = 0; stb_cycles = 0;
    s_adr = adr; s_sel = sel; s_we = we; s_wdat = wdat; s_cyc = 1'b1; s_stb = 1'b1;
    @(posedge clk);
    got = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      sample();
      if (s_ack || s_err) begin
        got = k; last_rdat = s_rdat; last_resp_err = s_err;
        break;
      end
      if (rst_lane >= 0 && m_stb && int'(m_adr[3:2]) == rst_lane) begin
        rst_hit = 1;
        break;
      end
      if (drop_cyc && k == 1) begin
        s_cyc = 1'b0; s_stb = 1'b0;
      end
      if (drop_cyc && k > 1 && !m_cyc) break;
    end
    s_cyc = 1'b0; s_stb = 1'b0;
    if (rst_lane >= 0) begin
      check({name, "_rst_lane_reached"}, 128'(rst_hit), 128'(1));
      rst_n = 1'b0;
      #1;
      check({name, "_rst_outputs_zero"}, 128'({s_rdat, s_ack, s_err, m_adr, m_sel, m_we,
                                               m_wdat, m_cyc, m_stb}), 128'(0));
      exp_q.delete();
      exp_resp_valid = 1'b0;
      @(negedge clk);
      sample();
      rst_n = 1'b1;
      return;
    end
    if (drop_cyc) begin
      check({name, "_no_resp"}, 128'(got), 128'(-1));
    end else begin
      check({name, "_latency"}, 128'(got), 128'(lat));
    end
    check({name, "_ds_beats"}, 128'(ds_beats), 128'(pops));
    if (slv_silent) check({name, "_stb_cycles"}, 128'(stb_cycles), 128'(TO));
    idle(2);
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    s_adr = '0; s_sel = '0; s_we = 1'b0; s_wdat = '0; s_cyc = 1'b0; s_stb = 1'b0;
    slv_err_lane = -1; slv_silent = 0; slv_both = 0;
    slv_word[0] = 32'h1111_0000; slv_word[1] = 32'h2222_0001;
    slv_word[2] = 32'hA5A5_5A5A; slv_word[3] = 32'h4444_0003;
    exp_resp_valid = 0; exp_resp_err = 0; exp_resp_rdat = '0;
    last_ds_adr = '0; last_ds_sel = '0; last_rdat = '0; last_resp_err = 0;

    repeat (2) @(negedge clk);
    check("reset_outputs_zero", 128'({s_rdat, s_ack, s_err, m_adr, m_sel, m_we, m_wdat,
                                      m_cyc, m_stb}), 128'(0));
    rst_n = 1'b1;

    // Single-lane read, accepted on the first edge after reset release.
    run_txn("rd_lane2", 32'h0000_1008, 16'h0F00, 1'b0, '0, 0, -1);
    check("rd_lane2_adr_lit", 128'(last_ds_adr), 128'(32'h0000_1008));
    check("rd_lane2_sel_lit", 128'(last_ds_sel), 128'(4'hF));
    check("rd_lane2_rdat_lit", last_rdat, {32'h0, 32'hA5A5_5A5A, 64'h0});

    // Four back-to-back writes; write responses carry zero data.
    run_txn("wr_all", 32'h2000_0000, 16'hFFFF, 1'b1,
            {32'h3, 32'h2, 32'h1, 32'h0}, 0, -1);
    check("wr_all_last_adr_lit", 128'(last_ds_adr), 128'(32'h2000_000C));
    check("wr_all_rdat_lit", last_rdat, 128'(0));

    run_txn("rd_all", 32'h0000_0040, 16'hFFFF, 1'b0, '0, 0, -1);
    run_txn("rd_partial", 32'h0000_300F, 16'h8421, 1'b0, '0, 0, -1);
    run_txn("wr_sparse", 32'h1234_5670, 16'h3005, 1'b1,
            {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 0, -1);

    // No active lanes: immediate ack with zero data.
    run_txn("sel_zero", 32'h0000_5550, 16'h0000, 1'b0, '0, 0, -1);
    check("sel_zero_rdat_lit", last_rdat, 128'(0));

    // Error on lane 1 abandons lane 3.
    slv_err_lane = 1;
    run_txn("rd_err", 32'h0000_4000, 16'hF0F0, 1'b0, '0, 0, -1);
    check("rd_err_kind_lit", 128'(last_resp_err), 128'(1));
    check("rd_err_adr_lit", 128'(last_ds_adr), 128'(32'h0000_4004));

    // Error together with ack: error wins, earlier lane data retained.
    slv_err_lane = 2; slv_both = 1;
    run_txn("rd_err_ack", 32'h0000_8000, 16'h0FF0, 1'b0, '0, 0, -1);
    slv_err_lane = -1; slv_both = 0;

    // Silent slave: timeout after TO strobe cycles.
    slv_silent = 1;
    run_txn("timeout", 32'h0000_9000, 16'h00F0, 1'b0, '0, 0, -1);
    check("timeout_kind_lit", 128'(last_resp_err), 128'(1));
    slv_silent = 0;

    run_txn("after_timeout", 32'h0000_A000, 16'h000F, 1'b0, '0, 0, -1);

    // Upstream abandons mid-access: downstream completes, response suppressed.
    run_txn("drop_cyc", 32'h5000_0010, 16'h0F0F, 1'b1, {4{32'h5A5A_0000}}, 1, -1);

    // Reset in the middle of lane 2 of a four-lane write, then a normal read.
    run_txn("wr_rst", 32'h6000_0000, 16'hFFFF, 1'b1,
            {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000}, 0, 2);
    run_txn("rd_post_rst", 32'h7000_0020, 16'h00FF, 1'b0, '0, 0, -1);
    check("rd_post_rst_rdat_lit", last_rdat, {64'h0, 32'h2222_0001, 32'h1111_0000});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_dsize_128to32.md
WB_DSIZE_128TO32 -- requirements
Module: wb_dsize_128to32

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, downstream cycles to wait for ack/err before flagging error (1..65535).
REQ-002 SHALL have port i_clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_s_wb_adr in 32, i_s_wb_sel in 16, i_s_wb_we in 1, i_s_wb_wdat in 128, i_s_wb_cyc in 1, i_s_wb_stb in 1: 128-bit Wishbone slave request from arbiter.
REQ-005 SHALL have ports o_s_wb_rdat out 128, o_s_wb_ack out 1, o_s_wb_err out 1: upstream response.
REQ-006 SHALL have ports o_m_wb_adr out 32, o_m_wb_sel out 4, o_m_wb_we out 1, o_m_wb_wdat out 32, o_m_wb_cyc out 1, o_m_wb_stb out 1: 32-bit Wishbone master request to peripheral.
REQ-007 SHALL have ports i_m_wb_rdat in 32, i_m_wb_ack in 1, i_m_wb_err in 1: downstream response.

Function
REQ-008 SHALL split one 128-bit access into one 32-bit access per lane n (0..3) whose sel nibble i_s_wb_sel[4n+3:4n] is non-zero; no endian conversion.
REQ-009 SHALL use FSM IDLE, ACCESS, RESP; all outputs registered.
REQ-010 IDLE: on i_s_wb_cyc&i_s_wb_stb, latch adr, sel, we, wdat, build 4-bit lane mask, clear rdat buffer and error flag; mask non-zero -> ACCESS, mask zero -> RESP.
REQ-011 ACCESS: drive lowest pending lane n: adr={adr[31:4],n[1:0],2'b00}, sel=nibble n, wdat=word n, we latched, cyc=stb=1.
REQ-012 On i_m_wb_ack in ACCESS: store i_m_wb_rdat into rdat word n (reads only), clear mask bit n, reset timeout counter; remaining lanes -> next lane driven next cycle with cyc,stb held high; none -> RESP with cyc,stb low.
REQ-013 On i_m_wb_err in ACCESS (err wins if asserted with ack): set error flag, abandon remaining lanes, -> RESP.
REQ-014 Timeout counter SHALL count ACCESS cycles without ack/err; reaching TIMEOUT_CYCLES sets error flag, -> RESP.
REQ-015 RESP: assert exactly one of o_s_wb_ack/o_s_wb_err for exactly one cycle, o_s_wb_rdat valid that cycle, then -> IDLE.
REQ-016 Non-accessed lanes and all write responses SHALL return zero rdat.
REQ-017 Latency with zero-wait slave: acceptance cycle 0, upstream ack in cycle N+1 for N active lanes (sel=0 -> cycle 1).
REQ-018 Upstream cyc dropped mid-ACCESS SHALL not abort downstream; response in RESP suppressed if i_s_wb_cyc low.
REQ-019 o_s_wb_rdat, o_m_wb_* SHALL hold values outside their valid cycles (no X).

Reset
REQ-020 i_rst_n low SHALL immediately force IDLE, all outputs 0, mask/counter/flag/buffers 0, including mid-ACCESS (downstream cycle dropped without completion).
REQ-021 First request SHALL be accepted in the first rising edge after i_rst_n deasserts.

Structure
REQ-022 FSM state encoding, lane count (4), lane width (32) SHALL live in shared package wb_bridge_pkg.
REQ-023 Lowest-pending-lane selection SHALL be sub-module wb_lane_pri_enc (4-bit mask -> 2-bit index + valid).

Verification
REQ-024 Read adr 0x0000_1008, sel 0x0F00, zero-wait slave returning 0xA5A5_5A5A -> one downstream read adr 0x0000_1008 sel 0xF; upstream ack cycle 2, rdat[95:64]=0xA5A5_5A5A, other words 0.
REQ-025 Write adr 0x2000_0000, sel 0xFFFF, wdat words 0x0..0x3 -> four back-to-back writes adr 0x..00,04,08,0C with wdat 0x0,0x1,0x2,0x3, cyc held high; upstream ack cycle 5.
REQ-026 Read sel 0xF0F0, slave err on lane 1 -> lane 3 never issued, o_s_wb_err one cycle, o_s_wb_ack never.
REQ-027 TIMEOUT_CYCLES=8, slave never responds -> o_m_wb_stb high 8 cycles, then o_s_wb_err one cycle, FSM IDLE.
REQ-028 sel 0x0000 -> no downstream cycle, o_s_wb_ack cycle 1, rdat 0.
REQ-029 i_rst_n pulsed low during lane 2 of 4-lane write -> all outputs 0 same cycle; new read after reset completes normally.
